// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared word width, default reset PC and fetch FSM state encodings
package inst_fetch_unit_pkg;
    localparam int IFU_SIZE_WORD = 16;
    localparam logic [IFU_SIZE_WORD-1:0] IFU_RESET_PC = 16'h0000;
    typedef enum logic [1:0] {
        FS_FETCH  = 2'd0,
        FS_HOLD   = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/inst_fetch_unit_pc_register.sv
// pc_register: program counter with sync reset, load (priority) and increment
// ports: clk, reset, inc, load, target[W] in; pc[W] out
module pc_register #(
    parameter int W = 16,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] target,
    output logic [W-1:0] pc
);
    always_ff @(posedge clk)
        if (reset) pc <= INIT;
        else if (load) pc <= target;
        else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches words from memory at PC and hands them to the control unit
// ports: clk, reset; memory side readM/address out, data/inputReady in;
//        control side inst/inst_valid out, inst_ready/pc_load/pc_target/halt in; halted out
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int SIZE_WORD = IFU_SIZE_WORD,
    parameter logic [SIZE_WORD-1:0] RESET_PC = SIZE_WORD'(IFU_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 readM,
    output logic [SIZE_WORD-1:0] address,
    input  logic [SIZE_WORD-1:0] data,
    input  logic                 inputReady,
    output logic [SIZE_WORD-1:0] inst,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    input  logic                 pc_load,
    input  logic [SIZE_WORD-1:0] pc_target,
    input  logic                 halt,
    output logic                 halted
);
    fetch_state_t state;
    logic fetch_done, handshake;
    assign fetch_done = state == FS_FETCH && inputReady;
    assign handshake = state == FS_HOLD && inst_ready;
    // halt outranks a redirect on the same handshake
    pc_register #(.W(SIZE_WORD), .INIT(RESET_PC)) u_pc (
        .clk(clk),
        .reset(reset),
        .inc(fetch_done),
        .load(handshake && !halt && pc_load),
        .target(pc_target),
        .pc(address)
    );
    always_ff @(posedge clk)
        if (reset) begin
            state <= FS_FETCH;
            inst <= '0;
        end else if (fetch_done) begin
            state <= FS_HOLD;
            inst <= data;
        end else if (handshake)
            state <= halt ? FS_HALTED : FS_FETCH;
    assign readM = state == FS_FETCH;
    assign inst_valid = state == FS_HOLD;
    assign halted = state == FS_HALTED;
endmodule
